ysyx_22040127_mem_arbiter: RTL and testbench

Shares the single off-core memory port between the instruction-cache refill path and the data-cache refill/write-back path. It accepts burst requests from both sides, grants one at a time, sequences the address, write-data, read-data and write-response phases, and routes returned beats to the owner. The block sits between the two caches and the bus bridge. It is the sole source of the memory-busy status that the fetch, decode and memory stages stall on.

---
 rtl/ysyx_22040127_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_ysyx_22040127_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_mem_arbiter.sv
// rtl/ysyx_22040127_mem_arbiter.sv - icache/dcache arbiter for the shared burst memory port
module ysyx_22040127_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 3
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [LEN_W-1:0]    i_len,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  output logic                i_done,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [LEN_W-1:0]    d_len,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_wready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  output logic                d_done,

  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [LEN_W-1:0]    m_len,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_bvalid,

  output logic                arb_owner_d,
  output logic [2:0]          arb_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_WRESP = 3'd4
  } state_t;

  state_t           state;
  logic             owner_d;
  logic             last_grant_d;
  logic             holdoff;
  logic             holdoff_d;
  logic [LEN_W-1:0] cnt;

  logic i_elig;
  logic d_elig;
  logic grant_d;
  logic rd_last;

  // The side that just finished is masked for one IDLE cycle so its lagging req is not regranted.
  assign i_elig  = i_req && !(holdoff && !holdoff_d);
  assign d_elig  = d_req && !(holdoff && holdoff_d);
  assign grant_d = d_elig && (!i_elig || !last_grant_d);
  assign rd_last = (state == S_RDATA) && m_rvalid && m_rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      owner_d      <= 1'b0;
      last_grant_d <= 1'b0;
      holdoff      <= 1'b0;
      holdoff_d    <= 1'b0;
      cnt          <= '0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_len        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          holdoff <= 1'b0;
          if (i_elig || d_elig) begin
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            m_we         <= grant_d ? d_we : 1'b0;
            m_addr       <= grant_d ? d_addr : i_addr;
            m_len        <= grant_d ? d_len : i_len;
            state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_req_ready) begin
            cnt   <= '0;
            state <= m_we ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: begin
          if (m_wready) begin
            cnt <= cnt + 1'b1;
            if (cnt == m_len) state <= S_WRESP;
          end
        end
        // rlast from the bus ends the burst even if the beat count disagrees.
        S_RDATA: begin
          if (m_rvalid && m_rlast) begin
            state     <= S_IDLE;
            holdoff   <= 1'b1;
            holdoff_d <= owner_d;
          end
        end
        S_WRESP: begin
          if (m_bvalid) begin
            state     <= S_IDLE;
            holdoff   <= 1'b1;
            holdoff_d <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign arb_state   = state;
  assign arb_owner_d = owner_d && (state != S_IDLE);

  assign m_req_valid = (state == S_ADDR);
  assign m_wvalid    = (state == S_WDATA);
  assign m_wlast     = (state == S_WDATA) && (cnt == m_len);
  assign m_wdata     = d_wdata;
  assign m_wstrb     = d_wstrb;
  assign d_wready    = (state == S_WDATA) && m_wready;

  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign i_rvalid = (state == S_RDATA) && !owner_d && m_rvalid;
  assign d_rvalid = (state == S_RDATA) && owner_d && m_rvalid;
  assign i_done   = rd_last && !owner_d;
  assign d_done   = (rd_last && owner_d) || ((state == S_WRESP) && m_bvalid);

endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// tb/tb_ysyx_22040127_mem_arbiter.sv - directed bench for the memory arbiter
module tb_ysyx_22040127_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [2:0]  i_len;
  logic [63:0] i_rdata;
  logic        i_rvalid, i_done;
  logic        d_req, d_we;
  logic [31:0] d_addr;
  logic [2:0]  d_len;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;
  logic        d_wready;
  logic [63:0] d_rdata;
  logic        d_rvalid, d_done;
  logic        m_req_valid, m_req_ready, m_we;
  logic [31:0] m_addr;
  logic [2:0]  m_len;
  logic        m_wvalid, m_wready, m_wlast;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_rvalid, m_rlast, m_bvalid;
  logic [63:0] m_rdata;
  logic        arb_owner_d;
  logic [2:0]  arb_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040127_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_rdata(i_rdata),
    .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_we(m_we),
    .m_addr(m_addr), .m_len(m_len), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_bvalid(m_bvalid), .arb_owner_d(arb_owner_d), .arb_state(arb_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0; i_len = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_len = 0; d_wdata = 0; d_wstrb = 0;
    m_req_ready = 1; m_wready = 0; m_rvalid = 0; m_rdata = 0; m_rlast = 0; m_bvalid = 0;
    tick(); tick();
    #1;
    chk("rst_state", arb_state, 3'd0);
    chk("rst_req_valid", m_req_valid, 1'b0);
    chk("rst_owner", arb_owner_d, 1'b0);
    chk("rst_addr", m_addr, 32'h0);
    chk("rst_len", m_len, 3'd0);
    chk("rst_we", m_we, 1'b0);
    chk("rst_wvalid", m_wvalid, 1'b0);
    rst = 1'b0;

    // Simultaneous requests after reset: dcache wins, icache follows one cycle after d_done.
    i_req = 1; i_addr = 32'h2000; i_len = 0;
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_len = 1;
    tick(); #1;
    chk("tie_state", arb_state, 3'd1);
    chk("tie_owner", arb_owner_d, 1'b1);
    chk("tie_req_valid", m_req_valid, 1'b1);
    chk("tie_addr", m_addr, 32'h3000);
    chk("tie_len", m_len, 3'd1);
    tick();
    m_rvalid = 1; m_rdata = 64'h11; m_rlast = 0; #1;
    chk("tie_state_rd", arb_state, 3'd3);
    chk("tie_d_rvalid0", d_rvalid, 1'b1);
    chk("tie_i_rvalid0", i_rvalid, 1'b0);
    chk("tie_d_rdata0", d_rdata, 64'h11);
    chk("tie_d_done0", d_done, 1'b0);
    tick();
    m_rdata = 64'h12; m_rlast = 1; #1;
    chk("tie_d_done1", d_done, 1'b1);
    chk("tie_i_done1", i_done, 1'b0);
    tick();
    m_rvalid = 0; m_rlast = 0; #1;
    chk("tie_idle", arb_state, 3'd0);
    chk("tie_idle_owner", arb_owner_d, 1'b0);
    tick();
    d_req = 0; #1;
    chk("tie_i_grant", arb_state, 3'd1);
    chk("tie_i_owner", arb_owner_d, 1'b0);
    chk("tie_i_addr", m_addr, 32'h2000);
    tick();
    m_rvalid = 1; m_rdata = 64'h22; m_rlast = 1; #1;
    chk("tie_i_rvalid", i_rvalid, 1'b1);
    chk("tie_i_done", i_done, 1'b1);
    chk("tie_i_d_rvalid", d_rvalid, 1'b0);
    tick();
    i_req = 0; m_rvalid = 0; m_rlast = 0;
    tick();

    // icache read of 4 beats, then holdoff on the lagging i_req.
    i_req = 1; i_addr = 32'h1000; i_len = 3; #1;
    chk("ird_state0", arb_state, 3'd0);
    tick(); #1;
    chk("ird_req_valid", m_req_valid, 1'b1);
    chk("ird_state1", arb_state, 3'd1);
    chk("ird_we", m_we, 1'b0);
    chk("ird_len", m_len, 3'd3);
    tick();
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1; m_rdata = 64'hA0 + 64'(b); m_rlast = (b == 3); #1;
      chk("ird_state3", arb_state, 3'd3);
      chk("ird_rvalid", i_rvalid, 1'b1);
      chk("ird_rdata", i_rdata, 64'hA0 + 64'(b));
      chk("ird_done", i_done, (b == 3));
      tick();
    end
    m_rvalid = 0; m_rlast = 0; #1;
    chk("ird_idle", arb_state, 3'd0);
    chk("ird_idle_rvalid", i_rvalid, 1'b0);
    tick(); #1;
    chk("hold_no_grant", arb_state, 3'd0);
    chk("hold_no_req_valid", m_req_valid, 1'b0);
    tick();
    i_len = 0; #1;
    chk("hold_regrant", arb_state, 3'd1);
    chk("hold_regrant_owner", arb_owner_d, 1'b0);
    tick();
    m_rvalid = 1; m_rdata = 64'h33; m_rlast = 1; #1;
    chk("hold_done", i_done, 1'b1);
    tick();
    i_req = 0; m_rvalid = 0; m_rlast = 0;
    tick();

    // dcache write of 2 beats with two stall cycles on beat 0.
    d_req = 1; d_we = 1; d_addr = 32'h4000; d_len = 1; d_wdata = 64'hD0; d_wstrb = 8'hFF;
    m_wready = 0;
    tick(); #1;
    chk("wr_we", m_we, 1'b1);
    chk("wr_owner", arb_owner_d, 1'b1);
    tick(); #1;
    chk("wr_state", arb_state, 3'd2);
    chk("wr_wvalid", m_wvalid, 1'b1);
    chk("wr_stall0_wready", d_wready, 1'b0);
    chk("wr_stall0_wlast", m_wlast, 1'b0);
    chk("wr_wdata0", m_wdata, 64'hD0);
    tick(); #1;
    chk("wr_stall1_wready", d_wready, 1'b0);
    chk("wr_stall1_wlast", m_wlast, 1'b0);
    tick();
    m_wready = 1; #1;
    chk("wr_b0_wready", d_wready, 1'b1);
    chk("wr_b0_wlast", m_wlast, 1'b0);
    chk("wr_wstrb", m_wstrb, 8'hFF);
    tick();
    d_wdata = 64'hD1; #1;
    chk("wr_b1_wlast", m_wlast, 1'b1);
    chk("wr_b1_wready", d_wready, 1'b1);
    chk("wr_wdata1", m_wdata, 64'hD1);
    tick();
    m_wready = 0; #1;
    chk("wr_resp_state", arb_state, 3'd4);
    chk("wr_resp_wvalid", m_wvalid, 1'b0);
    chk("wr_resp_nodone", d_done, 1'b0);
    tick();
    m_bvalid = 1; #1;
    chk("wr_done", d_done, 1'b1);
    chk("wr_i_done", i_done, 1'b0);
    tick();
    m_bvalid = 0; d_req = 0; #1;
    chk("wr_idle", arb_state, 3'd0);
    chk("wr_idle_done", d_done, 1'b0);
    tick();

    // Early rlast on a d_len=7 read ends the burst on beat 2.
    d_req = 1; d_we = 0; d_addr = 32'h5000; d_len = 7;
    tick(); #1;
    chk("er_len", m_len, 3'd7);
    tick();
    for (int b = 0; b < 3; b++) begin
      m_rvalid = 1; m_rdata = 64'hE0 + 64'(b); m_rlast = (b == 2); #1;
      chk("er_rvalid", d_rvalid, 1'b1);
      chk("er_done", d_done, (b == 2));
      tick();
    end
    m_rvalid = 0; m_rlast = 0; d_req = 0; #1;
    chk("er_idle", arb_state, 3'd0);
    tick();

    // Reset in the middle of a write burst, then a fresh single-beat write.
    d_req = 1; d_we = 1; d_addr = 32'h6000; d_len = 3; m_wready = 1;
    tick(); tick(); #1;
    chk("rw_state_wdata", arb_state, 3'd2);
    tick();
    rst = 1;
    tick();
    #1;
    chk("rw_rst_state", arb_state, 3'd0);
    chk("rw_rst_wvalid", m_wvalid, 1'b0);
    chk("rw_rst_wready", d_wready, 1'b0);
    chk("rw_rst_addr", m_addr, 32'h0);
    rst = 0; d_len = 0;
    tick(); #1;
    chk("rw_fresh_addr", arb_state, 3'd1);
    chk("rw_fresh_len", m_len, 3'd0);
    chk("rw_fresh_we", m_we, 1'b1);
    tick(); #1;
    chk("rw_fresh_wlast", m_wlast, 1'b1);
    chk("rw_fresh_wready", d_wready, 1'b1);
    tick();
    m_bvalid = 1; #1;
    chk("rw_fresh_done", d_done, 1'b1);
    tick();
    m_bvalid = 0; d_req = 0; m_wready = 0; #1;
    chk("rw_fresh_idle", arb_state, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
